// File: rtl/maxnet_pkg.sv
// Shared definitions for the 4-neuron winner-take-all Maxnet engine.
package maxnet_pkg;
  localparam int N          = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC   = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [DEF_DATA_W-1:0] act_t;
  typedef logic [DEF_DATA_W+1:0] acc_t;
endpackage

// File: rtl/maxnet_neuron.sv
// One Maxnet neuron: next = relu(self - ((sum of others * eps) >> FRAC)).
module maxnet_neuron #(
  parameter int DATA_W = maxnet_pkg::DEF_DATA_W,
  parameter int FRAC   = maxnet_pkg::DEF_FRAC
) (
  input  logic [DATA_W-1:0] i_self,
  input  logic [DATA_W-1:0] i_oth0,
  input  logic [DATA_W-1:0] i_oth1,
  input  logic [DATA_W-1:0] i_oth2,
  input  logic [DATA_W-1:0] i_eps,
  output logic [DATA_W-1:0] o_next
);
  localparam int SUM_W  = DATA_W + 2;
  localparam int PROD_W = SUM_W + DATA_W;

  logic        [SUM_W-1:0]  w_sum;
  logic        [PROD_W-1:0] w_prod;
  logic        [PROD_W-1:0] w_inhib;
  logic signed [PROD_W:0]   w_diff;

  // The difference can only shrink the activation, so only the lower clamp is needed.
  function automatic logic [DATA_W-1:0] relu(input logic signed [PROD_W:0] x);
    if (x < 0) return '0;
    return DATA_W'(x);
  endfunction

  always_comb begin
    w_sum   = SUM_W'(i_oth0) + SUM_W'(i_oth1) + SUM_W'(i_oth2);
    w_prod  = PROD_W'(w_sum) * PROD_W'(i_eps);
    w_inhib = w_prod >> FRAC;
    w_diff  = $signed({1'b0, PROD_W'(i_self)}) - $signed({1'b0, w_inhib});
    o_next  = relu(w_diff);
  end
endmodule

// File: rtl/maxnet_engine.sv
// Maxnet accelerator: loads four activations on start, iterates lateral
// inhibition until at most one survives, then reports the winner.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                FRAC     = DEF_FRAC,
  parameter int                EPS      = 3277,
  parameter logic [DATA_W-1:0] INIT0    = 16'h0CCD,
  parameter logic [DATA_W-1:0] INIT1    = 16'h199A,
  parameter logic [DATA_W-1:0] INIT2    = 16'h2666,
  parameter logic [DATA_W-1:0] INIT3    = 16'h3333,
  parameter int                MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic [1:0]        winner,
  output logic [DATA_W-1:0] max_val
);
  localparam int CNT_W = $clog2(MAX_ITER + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_act [N];
  logic [DATA_W-1:0] w_next [N];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic [1:0]        r_winner;
  logic [DATA_W-1:0] r_max_val;

  logic              w_load;
  logic              w_update;
  logic              w_finish;
  logic [2:0]        w_nz_cnt;
  logic [1:0]        w_win_idx;
  logic [DATA_W-1:0] w_win_val;
  logic [DATA_W-1:0] w_eps;

  assign w_eps = DATA_W'(EPS);

  for (genvar g = 0; g < N; g++) begin : g_neuron
    maxnet_neuron #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC)
    ) u_neuron (
      .i_self (r_act[g]),
      .i_oth0 (r_act[(g + 1) % N]),
      .i_oth1 (r_act[(g + 2) % N]),
      .i_oth2 (r_act[(g + 3) % N]),
      .i_eps  (w_eps),
      .o_next (w_next[g])
    );
  end

  // Strict '>' keeps the lowest index on ties; all-zero falls back to neuron 0.
  always_comb begin
    w_nz_cnt  = '0;
    w_win_idx = '0;
    w_win_val = r_act[0];
    for (int i = 0; i < N; i++) begin
      if (r_act[i] != '0) w_nz_cnt = w_nz_cnt + 3'd1;
      if (r_act[i] > w_win_val) begin
        w_win_idx = 2'(i);
        w_win_val = r_act[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_update    = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ITER;
        end
      end
      ST_ITER: begin
        if (w_nz_cnt <= 3'd1 || r_cnt == CNT_W'(MAX_ITER)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_update = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_winner  <= '0;
      r_max_val <= '0;
      for (int i = 0; i < N; i++) r_act[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_act[0] <= INIT0;
        r_act[1] <= INIT1;
        r_act[2] <= INIT2;
        r_act[3] <= INIT3;
        r_cnt    <= '0;
        r_ready  <= 1'b0;
      end else if (w_update) begin
        for (int i = 0; i < N; i++) r_act[i] <= w_next[i];
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_finish) begin
        r_winner  <= w_win_idx;
        r_max_val <= w_win_val;
        r_ready   <= 1'b1;
      end
    end
  end

  assign ready   = r_ready;
  assign winner  = r_winner;
  assign max_val = r_max_val;
endmodule

// File: tb/tb_maxnet_engine.sv
// Directed scoreboard bench for maxnet_engine (three parameterisations).
module tb_maxnet_engine;
  import maxnet_pkg::*;

  localparam int MAXIT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st  = '0;
  logic [2:0]  rdy;
  logic [1:0]  win [3];
  act_t        mv  [3];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] win;
    act_t       val;
    int         lat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  maxnet_engine dut (
    .clk(clk), .rst(rst), .start(st[0]), .ready(rdy[0]), .winner(win[0]), .max_val(mv[0])
  );
  maxnet_engine #(
    .INIT0(16'h0000), .INIT1(16'h0000), .INIT2(16'h2000), .INIT3(16'h0000)
  ) dut_b (
    .clk(clk), .rst(rst), .start(st[1]), .ready(rdy[1]), .winner(win[1]), .max_val(mv[1])
  );
  maxnet_engine #(
    .INIT0(16'h1000), .INIT1(16'h1000), .INIT2(16'h1000), .INIT3(16'h1000)
  ) dut_c (
    .clk(clk), .rst(rst), .start(st[2]), .ready(rdy[2]), .winner(win[2]), .max_val(mv[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference of the whole run: returns winner, value, edges to ready.
  task automatic model(input int i0, input int i1, input int i2, input int i3,
                       output int w, output int v, output int lat);
    int a [4];
    int n [4];
    int nz, k, s, p, d;
    a[0] = i0; a[1] = i1; a[2] = i2; a[3] = i3;
    k = 0;
    while (1) begin
      nz = 0;
      for (int i = 0; i < 4; i++) if (a[i] != 0) nz++;
      if (nz <= 1 || k == MAXIT) break;
      for (int i = 0; i < 4; i++) begin
        s = a[0] + a[1] + a[2] + a[3] - a[i];
        p = int'((longint'(s) * 64'd3277) >> 14);
        d = a[i] - p;
        n[i] = (d < 0) ? 0 : d;
      end
      for (int i = 0; i < 4; i++) a[i] = n[i];
      k++;
    end
    w = 0; v = a[0];
    for (int i = 1; i < 4; i++) if (a[i] > v) begin w = i; v = a[i]; end
    lat = k + 1;
  endtask

  task automatic kick(input int id, input int i0, input int i1, input int i2, input int i3,
                      input string tag);
    exp_t e;
    int w, v, l;
    model(i0, i1, i2, i3, w, v, l);
    e.win = w[1:0];
    e.val = v[15:0];
    e.lat = l;
    q.push_back(e);
    @(negedge clk);
    st[id] = 1'b1;
    @(posedge clk);
    #1;
    st[id] = 1'b0;
    chk({tag, "_ready_low"}, 32'(rdy[id]), 32'd0);
  endtask

  task automatic finish(input int id, input int lat0, input bit disturb, input string tag,
                        output int lat);
    exp_t e;
    lat = lat0;
    while (rdy[id] !== 1'b1 && lat < MAXIT + 10) begin
      st[id] = (disturb && lat == 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    st[id] = 1'b0;
    chk({tag, "_ready"}, 32'(rdy[id]), 32'd1);
    e = q.pop_front();
    chk({tag, "_winner"}, 32'(win[id]), 32'(e.win));
    chk({tag, "_max_val"}, 32'(mv[id]), 32'(e.val));
    chk({tag, "_latency"}, lat, e.lat);
  endtask

  initial begin
    int lat;
    int a3_exp;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_winner", 32'(win[0]), 32'd0);
    chk("rst_max_val", 32'(mv[0]), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // Test 1: default inputs, then rerun 20 cycles later
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t1");
    finish(0, 0, 1'b0, "t1", lat);
    chk("t1_val_pos", 32'(mv[0] > 16'd0), 32'd1);
    chk("t1_val_le_init", 32'(mv[0] <= 16'h3333), 32'd1);
    chk("t1_a0", 32'(dut.r_act[0]), 32'd0);
    chk("t1_a1", 32'(dut.r_act[1]), 32'd0);
    chk("t1_a2", 32'(dut.r_act[2]), 32'd0);
    chk("t1_lat_bound", 32'(lat <= MAXIT + 1), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_ready_held", 32'(rdy[0]), 32'd1);
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t1b");
    finish(0, 0, 1'b0, "t1b", lat);

    // Test 2: single non-zero neuron
    kick(1, 16'h0000, 16'h0000, 16'h2000, 16'h0000, "t2");
    finish(1, 0, 1'b0, "t2", lat);

    // Test 3: equal inputs decay together
    kick(2, 16'h1000, 16'h1000, 16'h1000, 16'h1000, "t3");
    finish(2, 0, 1'b0, "t3", lat);
    chk("t3_lat_bound", 32'(lat <= MAXIT + 1), 32'd1);

    // Test 4: start pulse during ITER is ignored
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t4");
    finish(0, 0, 1'b1, "t4", lat);

    // Test 6: bit-exact first update step
    a3_exp = 16'h3333 - int'((longint'(16'h0CCD + 16'h199A + 16'h2666) * 64'd3277) >> 14);
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t6");
    @(posedge clk);
    #1;
    chk("t6_a0", 32'(dut.r_act[0]), 32'd0);
    chk("t6_a3", 32'(dut.r_act[3]), 32'(a3_exp));
    chk("t6_cnt", 32'(dut.r_cnt), 32'd1);
    finish(0, 1, 1'b0, "t6", lat);

    // Test 5: asynchronous reset mid-ITER, then a clean run
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t5");
    q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_ready", 32'(rdy[0]), 32'd0);
    chk("t5_winner", 32'(win[0]), 32'd0);
    chk("t5_max_val", 32'(mv[0]), 32'd0);
    chk("t5_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("t5_a3", 32'(dut.r_act[3]), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    kick(0, 16'h0CCD, 16'h199A, 16'h2666, 16'h3333, "t5b");
    finish(0, 0, 1'b0, "t5b", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
